// File: rtl/d_ff_pipe_rst.sv
// d_ff_pipe_rst: elastic DEPTH-stage, WIDTH-bit register pipeline with
// valid/ready handshakes on both sides and collapsing bubbles.
// Ports: clk; reset (async, active-high); flush (sync clear of all valids);
//   in_valid/in_ready/d upstream; out_valid/out_ready/q/q_bar downstream;
//   count = number of valid stages (0..DEPTH).
module d_ff_pipe_rst #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           d,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           q_bar,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]               count_q, count_d;

    logic [DEPTH-1:0]            rdy;
    logic                        rdy_run;
    // Index i of these is the predecessor of stage i; slot 0 is the input.
    logic [DEPTH:0]              v_src;
    logic [DEPTH:0][WIDTH-1:0]   d_src;
    logic                        accept;
    logic                        drain;

    // Walk from the output back: a stage is ready if it is empty or
    // everything downstream of it can move.
    always_comb begin
        rdy     = '0;
        rdy_run = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy_run = !valid_q[i] || rdy_run;
            rdy[i]  = rdy_run;
        end
    end

    assign in_ready  = rdy[0] && !flush && !reset;
    assign accept    = in_valid && in_ready;
    assign out_valid = valid_q[DEPTH-1];
    assign drain     = out_valid && out_ready;
    assign q         = data_q[DEPTH-1];
    assign q_bar     = ~q;
    assign count     = count_q;

    assign v_src = {valid_q, accept};
    assign d_src = {data_q, d};

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i]) begin
                valid_d[i] = v_src[i];
            end
            // Data only moves with a real word, so bubbles never toggle it;
            // a flush leaves all data registers untouched.
            if (rdy[i] && v_src[i] && !flush) begin
                data_d[i] = d_src[i];
            end
        end
        count_d = count_q + CW'(accept) - CW'(drain);
        if (flush) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= {DEPTH{RESET_VALUE}};
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_d_ff_pipe_rst.sv
// tb_d_ff_pipe_rst: directed checks of d_ff_pipe_rst
// WIDTH=8, DEPTH=4, RESET_VALUE=8'hA5
module tb_d_ff_pipe_rst;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] d = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] q;
  logic [7:0] q_bar;
  logic [2:0] count;

  int nvec = 0;
  int nerr = 0;

  d_ff_pipe_rst #(
    .WIDTH      (8),
    .DEPTH      (4),
    .RESET_VALUE(8'hA5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .d        (d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .q        (q),
    .q_bar    (q_bar),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input bit ok);
    nvec++;
    if (!ok) begin
      nerr++;
      $error("FAIL %s", tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2 reset = 1'b1;
    #1;
    chk("rst_q", q === 8'hA5);
    chk("rst_qbar", q_bar === 8'h5A);
    chk("rst_ovalid", out_valid === 1'b0);
    chk("rst_count", count === 3'd0);
    chk("rst_iready", in_ready === 1'b0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_iready", in_ready === 1'b1);
    tick();

    out_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      if (k <= 8) begin
        in_valid = 1'b1;
        d = 8'(k);
        #1;
        chk("str_iready", in_ready === 1'b1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      chk("str_ovalid",
          out_valid === (k >= 4 && k <= 11));
      if (k >= 4 && k <= 11) begin
        chk("str_q", q === 8'(k - 3));
      end
      if (k <= 8) begin
        chk("str_count",
            count === 3'((k < 4) ? k : 4));
      end else begin
        chk("str_count", count === 3'(12 - k));
      end
    end

    out_ready = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      in_valid = 1'b1;
      d = 8'(w);
      #1;
      chk("fill_iready", in_ready === 1'b1);
      tick();
    end
    d = 8'h05;
    #1;
    chk("full_iready", in_ready === 1'b0);
    chk("full_count", count === 3'd4);
    chk("full_ovalid", out_valid === 1'b1);
    chk("full_q", q === 8'h01);
    tick();
    chk("hold_q", q === 8'h01);
    chk("hold_count", count === 3'd4);
    out_ready = 1'b1;
    #1;
    chk("full_drain_iready", in_ready === 1'b1);
    tick();
    in_valid = 1'b0;
    chk("swap_q", q === 8'h02);
    chk("swap_count", count === 3'd4);
    for (int j = 3; j <= 5; j++) begin
      tick();
      chk("drain_ovalid", out_valid === 1'b1);
      chk("drain_q", q === 8'(j));
      chk("drain_count", count === 3'(6 - j));
    end
    tick();
    chk("drain_empty", out_valid === 1'b0);
    chk("drain_count0", count === 3'd0);

    out_ready = 1'b0;
    in_valid = 1'b1;
    d = 8'h11;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    in_valid = 1'b1;
    d = 8'h22;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("bub_count", count === 3'd2);
    chk("bub_ovalid", out_valid === 1'b1);
    chk("bub_q", q === 8'h11);
    chk("bub_iready", in_ready === 1'b1);
    tick();
    chk("bub_hold_q", q === 8'h11);
    out_ready = 1'b1;
    tick();
    chk("bub_q2", q === 8'h22);
    chk("bub_count1", count === 3'd1);
    tick();
    chk("bub_empty", out_valid === 1'b0);
    chk("bub_count0", count === 3'd0);

    out_ready = 1'b0;
    in_valid = 1'b1;
    d = 8'hAA;
    tick();
    d = 8'hBB;
    tick();
    d = 8'hCC;
    tick();
    chk("fl_count3", count === 3'd3);
    flush = 1'b1;
    d = 8'hFF;
    #1;
    chk("fl_iready", in_ready === 1'b0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_count0", count === 3'd0);
    chk("fl_ovalid", out_valid === 1'b0);
    chk("fl_data_kept", q === 8'h22);
    chk("fl_qbar", q_bar === 8'hDD);
    tick();
    tick();
    tick();
    tick();
    chk("fl_no_ff", count === 3'd0);
    chk("fl_no_ff_v", out_valid === 1'b0);

    in_valid = 1'b1;
    d = 8'h31;
    tick();
    d = 8'h32;
    tick();
    d = 8'h33;
    tick();
    in_valid = 1'b0;
    chk("mr_count3", count === 3'd3);
    #2 reset = 1'b1;
    #1;
    chk("mr_count", count === 3'd0);
    chk("mr_q", q === 8'hA5);
    chk("mr_ovalid", out_valid === 1'b0);
    chk("mr_iready", in_ready === 1'b0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    d = 8'h3C;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mr_not_yet", out_valid === 1'b0);
    tick();
    chk("mr_ovalid3c", out_valid === 1'b1);
    chk("mr_q3c", q === 8'h3C);
    chk("mr_count1", count === 3'd1);
    tick();
    chk("mr_alone", out_valid === 1'b0);
    chk("mr_count0", count === 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
